// File: rtl/riscv_mstage_ldu.sv
// Memory-stage load unit: load-source select, data-memory handshake with
// timeout, load-data extension and a bank of synchronised, debounced input
// channels with sticky rising-edge event flags.
module riscv_mstage_ldu #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned NCH    = 8,
  parameter int unsigned CHW    = 8,
  parameter int unsigned DB_CYC = 50000,
  parameter int unsigned TMO    = 255
) (
  input  logic                        i_riscv_ldu_clk,
  input  logic                        i_riscv_ldu_rst,
  input  logic                        i_riscv_ldu_ld_en,
  input  logic [$clog2(NCH+2)-1:0]    i_riscv_ldu_sel,
  input  logic [XLEN-1:0]             i_riscv_ldu_addr,
  input  logic [2:0]                  i_riscv_ldu_memext,
  input  logic [XLEN-1:0]             i_riscv_ldu_dm_rdata,
  input  logic                        i_riscv_ldu_dm_valid,
  input  logic [XLEN-1:0]             i_riscv_ldu_timer_rdata,
  input  logic [NCH*CHW-1:0]          i_riscv_ldu_ch_in,
  output logic                        o_riscv_ldu_dm_req,
  output logic                        o_riscv_ldu_stall,
  output logic [XLEN-1:0]             o_riscv_ldu_memload,
  output logic                        o_riscv_ldu_valid,
  output logic                        o_riscv_ldu_err,
  output logic [NCH-1:0]              o_riscv_ldu_ch_event
);

  localparam int unsigned SW  = $clog2(NCH+2);
  localparam int unsigned TW  = (TMO > 0) ? $clog2(TMO+1) : 1;
  localparam int unsigned DBW = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]         state, state_d;
  logic [TW-1:0]      cnt, cnt_d;
  logic               dm_req_d, valid_d, err_d, stall_c;
  logic [XLEN-1:0]    memload_d;
  logic [XLEN-1:0]    shifted, ext, src;
  logic [NCH*CHW-1:0] db_flat;
  logic [NCH-1:0]     ev_clr;

  // Align the addressed bytes to bit 0 and apply the load-type extension.
  always_comb begin
    shifted = i_riscv_ldu_dm_rdata >> {i_riscv_ldu_addr[2:0], 3'b000};
    case (i_riscv_ldu_memext)
      3'b000:  ext = {{(XLEN-8){shifted[7]}},   shifted[7:0]};
      3'b001:  ext = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      3'b010:  ext = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
      3'b100:  ext = {{(XLEN-8){1'b0}},  shifted[7:0]};
      3'b101:  ext = {{(XLEN-16){1'b0}}, shifted[15:0]};
      3'b110:  ext = {{(XLEN-32){1'b0}}, shifted[31:0]};
      default: ext = shifted;
    endcase
  end

  // Non-memory source mux: timer, debounced channels, zero for unused codes.
  always_comb begin
    src = '0;
    if (i_riscv_ldu_sel == SW'(1)) src = i_riscv_ldu_timer_rdata;
    for (int k = 0; k < NCH; k++) begin
      if (i_riscv_ldu_sel == SW'(k+2)) src = XLEN'(db_flat[k*CHW +: CHW]);
    end
  end

  // Next-state and registered-output decode for the load handshake.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    dm_req_d  = 1'b0;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    memload_d = o_riscv_ldu_memload;
    stall_c   = 1'b0;
    ev_clr    = '0;
    case (state)
      IDLE: begin
        if (i_riscv_ldu_ld_en) begin
          if (i_riscv_ldu_sel == '0) begin
            stall_c  = 1'b1;
            dm_req_d = 1'b1;
            cnt_d    = '0;
            state_d  = WAIT;
          end else begin
            memload_d = src;
            valid_d   = 1'b1;
            for (int k = 0; k < NCH; k++) begin
              ev_clr[k] = (i_riscv_ldu_sel == SW'(k+2));
            end
          end
        end
      end
      WAIT: begin
        stall_c = 1'b1;
        if (i_riscv_ldu_dm_valid) begin
          memload_d = ext;
          valid_d   = 1'b1;
          state_d   = DONE;
        end else if (cnt == TW'(TMO)) begin
          memload_d = '0;
          err_d     = 1'b1;
          valid_d   = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d = cnt + TW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign o_riscv_ldu_stall = stall_c;

  // State and registered outputs.
  always_ff @(posedge i_riscv_ldu_clk or negedge i_riscv_ldu_rst) begin
    if (!i_riscv_ldu_rst) begin
      state               <= IDLE;
      cnt                 <= '0;
      o_riscv_ldu_dm_req  <= 1'b0;
      o_riscv_ldu_valid   <= 1'b0;
      o_riscv_ldu_err     <= 1'b0;
      o_riscv_ldu_memload <= '0;
    end else begin
      state               <= state_d;
      cnt                 <= cnt_d;
      o_riscv_ldu_dm_req  <= dm_req_d;
      o_riscv_ldu_valid   <= valid_d;
      o_riscv_ldu_err     <= err_d;
      o_riscv_ldu_memload <= memload_d;
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [CHW-1:0] s1, s2, last, db;
    logic [DBW-1:0] dcnt, eff;
    logic           upd, ev;

    // A change in the synchronised value restarts the stability count.
    assign eff = (s2 != last) ? '0 : dcnt;
    assign upd = (s2 != db) && (eff == DBW'(DB_CYC-1));

    // Synchroniser, debounce counter and sticky event (set beats clear).
    always_ff @(posedge i_riscv_ldu_clk or negedge i_riscv_ldu_rst) begin
      if (!i_riscv_ldu_rst) begin
        s1   <= '0;
        s2   <= '0;
        last <= '0;
        db   <= '0;
        dcnt <= '0;
        ev   <= 1'b0;
      end else begin
        s1   <= i_riscv_ldu_ch_in[k*CHW +: CHW];
        s2   <= s1;
        last <= s2;
        if (s2 != db) begin
          if (upd) begin
            db   <= s2;
            dcnt <= '0;
          end else begin
            dcnt <= eff + DBW'(1);
          end
        end else begin
          dcnt <= '0;
        end
        if (upd && s2[0] && !db[0]) ev <= 1'b1;
        else if (ev_clr[k])         ev <= 1'b0;
      end
    end

    assign db_flat[k*CHW +: CHW] = db;
    assign o_riscv_ldu_ch_event[k] = ev;
  end

endmodule

// File: tb/tb_riscv_mstage_ldu.sv
// Directed self-checking bench for riscv_mstage_ldu.
module tb_riscv_mstage_ldu;

  localparam int unsigned NCH = 8;
  localparam int unsigned CHW = 8;
  localparam int unsigned SW  = $clog2(NCH+2);

  logic              clk = 1'b0;
  logic              rst;
  logic              ld_en;
  logic [SW-1:0]     sel;
  logic [63:0]       addr;
  logic [2:0]        memext;
  logic [63:0]       dm_rdata;
  logic              dm_valid;
  logic [63:0]       timer;
  logic [NCH*CHW-1:0] ch_in;
  logic              dm_req, stall, valid, err;
  logic [63:0]       memload;
  logic [NCH-1:0]    ch_event;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  riscv_mstage_ldu #(.XLEN(64), .NCH(NCH), .CHW(CHW), .DB_CYC(4), .TMO(255)) dut (
    .i_riscv_ldu_clk         (clk),
    .i_riscv_ldu_rst         (rst),
    .i_riscv_ldu_ld_en       (ld_en),
    .i_riscv_ldu_sel         (sel),
    .i_riscv_ldu_addr        (addr),
    .i_riscv_ldu_memext      (memext),
    .i_riscv_ldu_dm_rdata    (dm_rdata),
    .i_riscv_ldu_dm_valid    (dm_valid),
    .i_riscv_ldu_timer_rdata (timer),
    .i_riscv_ldu_ch_in       (ch_in),
    .o_riscv_ldu_dm_req      (dm_req),
    .o_riscv_ldu_stall       (stall),
    .o_riscv_ldu_memload     (memload),
    .o_riscv_ldu_valid       (valid),
    .o_riscv_ldu_err         (err),
    .o_riscv_ldu_ch_event    (ch_event)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Data-memory load with dm_valid presented in the lat-th WAIT cycle.
  task automatic dm_load(input string tag, input logic [2:0] ext, input logic [63:0] ad,
                         input logic [63:0] rd, input int lat, input logic [63:0] exp);
    int stalls = 0;
    int reqs   = 0;
    int early  = 0;
    ld_en = 1'b1; sel = '0; addr = ad; memext = ext; dm_rdata = rd; dm_valid = 1'b0;
    #1;
    if (stall) stalls++;
    for (int c = 1; c <= lat; c++) begin
      tick();
      if (dm_req) reqs++;
      if (valid) early++;
      if (c == lat) dm_valid = 1'b1;
      #1;
      if (stall) stalls++;
    end
    tick();
    dm_valid = 1'b0;
    if (dm_req) reqs++;
    chk({tag, "_data"},  memload, exp);
    chk({tag, "_valid"}, valid, 1'b1);
    chk({tag, "_err"},   err, 1'b0);
    chk({tag, "_stall_done"}, stall, 1'b0);
    chk({tag, "_stall_cycles"}, 64'(stalls), 64'(lat + 1));
    chk({tag, "_req_pulses"}, 64'(reqs), 64'd1);
    chk({tag, "_early_valid"}, 64'(early), 64'd0);
    ld_en = 1'b0;
    tick();
    chk({tag, "_valid_drop"}, valid, 1'b0);
  endtask

  initial begin
    int stalls;
    int bad;
    rst = 1'b0; ld_en = 1'b0; sel = '0; addr = '0; memext = '0;
    dm_rdata = '0; dm_valid = 1'b0; timer = '0; ch_in = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dm_req", dm_req, 1'b0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_memload", memload, 64'h0);
    chk("rst_valid", valid, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_ch_event", ch_event, 8'h00);
    rst = 1'b1;
    tick();

    // Extension cases
    dm_load("lb",  3'b000, 64'd3, 64'h0000_0000_8000_0000, 3, 64'hFFFF_FFFF_FFFF_FF80);
    dm_load("lbu", 3'b100, 64'd3, 64'h0000_0000_8000_0000, 3, 64'h0000_0000_0000_0080);
    dm_load("lw",  3'b010, 64'd4, 64'h8765_4321_0000_0000, 1, 64'hFFFF_FFFF_8765_4321);
    dm_load("lhu", 3'b101, 64'd6, 64'h8765_4321_0000_0000, 2, 64'h0000_0000_0000_8765);

    // Timeout: no dm_valid
    ld_en = 1'b1; sel = '0; memext = 3'b011; addr = '0; dm_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    #1;
    stalls = stall ? 1 : 0;
    bad = 0;
    for (int i = 1; i <= 256; i++) begin
      tick();
      if (stall) stalls++;
      if (err || valid) bad++;
    end
    chk("tmo_early", 64'(bad), 64'd0);
    chk("tmo_stall_cycles", 64'(stalls), 64'd257);
    tick();
    chk("tmo_err", err, 1'b1);
    chk("tmo_valid", valid, 1'b1);
    chk("tmo_data", memload, 64'h0);
    chk("tmo_stall_drop", stall, 1'b0);
    ld_en = 1'b0;
    tick();
    chk("tmo_err_pulse", err, 1'b0);

    // Back-to-back timer loads, then unused code, then immediate memory load
    ld_en = 1'b1; sel = SW'(1);
    timer = 64'h1234_5678_9ABC_DEF0; #1; chk("tmr0_stall", stall, 1'b0);
    tick(); chk("tmr0_data", memload, 64'h1234_5678_9ABC_DEF0); chk("tmr0_valid", valid, 1'b1);
    timer = 64'h0FED_CBA9_8765_4321; #1; chk("tmr1_stall", stall, 1'b0);
    tick(); chk("tmr1_data", memload, 64'h0FED_CBA9_8765_4321); chk("tmr1_valid", valid, 1'b1);
    timer = 64'hFFFF_0000_FFFF_0000; #1; chk("tmr2_stall", stall, 1'b0);
    tick(); chk("tmr2_data", memload, 64'hFFFF_0000_FFFF_0000); chk("tmr2_valid", valid, 1'b1);
    sel = SW'(12);
    tick(); chk("unused_sel_data", memload, 64'h0); chk("unused_sel_valid", valid, 1'b1);
    dm_load("after_periph", 3'b001, 64'd1, 64'h0000_0000_00F0_0100, 2, 64'hFFFF_FFFF_FFFF_F001);

    // Channel 2 glitch then held high
    ch_in[2*CHW +: CHW] = 8'h01;
    tick(); tick();
    ch_in[2*CHW +: CHW] = 8'h00;
    tick(); tick();
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (ch_event != 8'h00) bad++;
    end
    chk("glitch_no_event", 64'(bad), 64'd0);
    ch_in[2*CHW +: CHW] = 8'h01;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (ch_event != 8'h00) bad++;
    end
    chk("db_not_yet", 64'(bad), 64'd0);
    tick();
    chk("db_event2", ch_event, 8'h04);
    ld_en = 1'b1; sel = SW'(4);
    tick();
    chk("ch2_data", memload, 64'h1);
    chk("ch2_valid", valid, 1'b1);
    chk("ch2_event_clr", ch_event, 8'h00);
    ld_en = 1'b0;

    // Channel 3 rising edge coinciding with a channel-3 read
    ch_in[3*CHW +: CHW] = 8'h01;
    repeat (5) tick();
    ld_en = 1'b1; sel = SW'(5);
    tick();
    chk("coinc_event_kept", ch_event, 8'h08);
    chk("coinc_old_data", memload, 64'h0);
    tick();
    chk("ch3_event_clr", ch_event, 8'h00);
    chk("ch3_data", memload, 64'h1);
    ld_en = 1'b0;
    tick();

    // Reset in WAIT, late dm_valid ignored
    ld_en = 1'b1; sel = '0; memext = 3'b011; dm_rdata = 64'hAAAA_5555_AAAA_5555;
    tick();
    chk("rw_req", dm_req, 1'b1);
    tick();
    rst = 1'b0; ld_en = 1'b0;
    #1;
    chk("rw_async_stall", stall, 1'b0);
    chk("rw_async_memload", memload, 64'h0);
    chk("rw_async_event", ch_event, 8'h00);
    tick();
    rst = 1'b1;
    tick(); tick();
    dm_valid = 1'b1;
    tick();
    dm_valid = 1'b0;
    chk("rw_no_valid", valid, 1'b0);
    chk("rw_no_err", err, 1'b0);
    chk("rw_stall", stall, 1'b0);
    chk("rw_memload", memload, 64'h0);
    ld_en = 1'b1; sel = SW'(1); timer = 64'h5A5A_5A5A_0000_0001;
    tick();
    chk("rw_idle_accept", valid, 1'b1);
    chk("rw_idle_data", memload, 64'h5A5A_5A5A_0000_0001);
    ld_en = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
